// File: rtl/intr_ctrl_pkg.sv
// Shared types and helpers for the interrupt controller target.
package intr_ctrl_pkg;

  typedef enum logic [1:0] {
    GwIdle    = 2'd0,
    GwPending = 2'd1,
    GwInsvc   = 2'd2
  } gw_state_e;

  localparam int unsigned IdNone = 0;

  function automatic int unsigned id_width(input int unsigned num_src);
    return $clog2(num_src + 1);
  endfunction

endpackage

// File: rtl/intr_ctrl_gateway.sv
// Per-source gateway: IDLE/PENDING/INSVC FSM. Edge detection and the
// deferred-edge bit exist only when INTR_CTRL_EDGE_EN is defined.
module intr_ctrl_gateway
  import intr_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic intr_i,
  input  logic le_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic pending_o
);

  gw_state_e state_q, state_d;
  logic      trig;
  logic      rearm;

`ifdef INTR_CTRL_EDGE_EN
  logic intr_dly_q, intr_dly_d;
  logic defer_q, defer_d;
  logic rise;

  assign rise       = intr_i & ~intr_dly_q;
  assign intr_dly_d = intr_i;
  assign trig       = le_i ? rise : intr_i;
  // An edge landing on the completion cycle counts as deferred, otherwise it would be lost.
  assign rearm      = defer_q | (le_i & rise);

  always_comb begin
    defer_d = defer_q;
    if (state_q != GwInsvc || complete_i) begin
      defer_d = 1'b0;
    end else if (le_i && rise) begin
      defer_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      intr_dly_q <= 1'b0;
      defer_q    <= 1'b0;
    end else begin
      intr_dly_q <= intr_dly_d;
      defer_q    <= defer_d;
    end
  end
`else
  logic unused_le;
  assign unused_le = le_i;
  assign trig      = intr_i;
  assign rearm     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      GwIdle:    if (trig)       state_d = GwPending;
      GwPending: if (claim_i)    state_d = GwInsvc;
      GwInsvc:   if (complete_i) state_d = rearm ? GwPending : GwIdle;
      default:                   state_d = GwIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= GwIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign pending_o = (state_q == GwPending);

endmodule

// File: rtl/intr_ctrl_target.sv
// Interrupt target: NumSrc gateways plus a registered priority arbiter.
// Optional edge-trigger support is enabled with INTR_CTRL_EDGE_EN.
module intr_ctrl_target
  import intr_ctrl_pkg::*;
#(
  parameter  int unsigned NumSrc = 8,
  parameter  int unsigned PrioW  = 3,
  localparam int unsigned IdW    = id_width(NumSrc)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumSrc-1:0]       intr_i,
  input  logic [NumSrc-1:0]       le_i,
  input  logic [NumSrc-1:0]       ie_i,
  input  logic [NumSrc*PrioW-1:0] prio_i,
  input  logic [PrioW-1:0]        threshold_i,
  input  logic                    claim_i,
  input  logic                    complete_i,
  input  logic [IdW-1:0]          complete_id_i,
  output logic [NumSrc-1:0]       ip_o,
  output logic                    irq_o,
  output logic [IdW-1:0]          irq_id_o
);

  logic           irq_q, irq_d;
  logic [IdW-1:0] irq_id_q, irq_id_d;
  logic           claim_hit;
  logic [PrioW-1:0] prio, best_prio;

  assign claim_hit = claim_i && (irq_id_q != IdW'(IdNone));

  for (genvar g = 0; g < NumSrc; g++) begin : g_gw
    intr_ctrl_gateway u_gw (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .intr_i     (intr_i[g]),
      .le_i       (le_i[g]),
      .claim_i    (claim_hit && (irq_id_q == IdW'(g + 1))),
      .complete_i (complete_i && (complete_id_i == IdW'(g + 1))),
      .pending_o  (ip_o[g])
    );
  end

  // The source being claimed this edge is masked so its ID is never presented again.
  always_comb begin
    irq_id_d  = IdW'(IdNone);
    best_prio = '0;
    prio      = '0;
    for (int unsigned i = 0; i < NumSrc; i++) begin
      prio = prio_i[i*PrioW +: PrioW];
      if (ip_o[i] && ie_i[i] && (prio > threshold_i) && (prio > best_prio) &&
          !(claim_hit && (irq_id_q == IdW'(i + 1)))) begin
        best_prio = prio;
        irq_id_d  = IdW'(i + 1);
      end
    end
    irq_d = (irq_id_d != IdW'(IdNone));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_q    <= 1'b0;
      irq_id_q <= '0;
    end else begin
      irq_q    <= irq_d;
      irq_id_q <= irq_id_d;
    end
  end

  assign irq_o    = irq_q;
  assign irq_id_o = irq_id_q;

endmodule

// File: tb/tb_intr_ctrl_target.sv
// Randomized + directed bench for intr_ctrl_target against a behavioural model.
module tb_intr_ctrl_target;
  localparam int N = 8;
  localparam int W = 3;
`ifdef INTR_CTRL_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] intr, le, ie, ip;
  logic [N*W-1:0] prio;
  logic [W-1:0] thr;
  logic         claim, complete, irq;
  logic [3:0]   cid, irq_id;

  int n_total = 0;
  int n_bad   = 0;

  // model: 0 idle, 1 pending, 2 in service
  int m_st[N];
  bit m_prev[N];
  bit m_defer[N];
  int m_id;

  always #5 clk = ~clk;

  intr_ctrl_target #(.NumSrc(8), .PrioW(3)) dut (
    .clk_i(clk), .rst_i(rst), .intr_i(intr), .le_i(le), .ie_i(ie),
    .prio_i(prio), .threshold_i(thr), .claim_i(claim), .complete_i(complete),
    .complete_id_i(cid), .ip_o(ip), .irq_o(irq), .irq_id_o(irq_id)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int get_prio(input int i);
    logic [W-1:0] p;
    p = prio[i*W +: W];
    return int'(p);
  endfunction

  // Highest eligible priority; strict > keeps the lowest index on a tie.
  function automatic int arbitrate(input int skip_id);
    int best_id = 0;
    int best_p  = 0;
    for (int i = 0; i < N; i++) begin
      if (m_st[i] == 1 && ie[i] && get_prio(i) > int'(thr) && get_prio(i) > best_p
          && (i + 1) != skip_id) begin
        best_p  = get_prio(i);
        best_id = i + 1;
      end
    end
    return best_id;
  endfunction

  task automatic model_step();
    int claimed, nid;
    bit rise, trig;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_st[i] = 0; m_prev[i] = 0; m_defer[i] = 0;
      end
      m_id = 0;
      return;
    end
    claimed = (claim && m_id != 0) ? m_id : 0;
    nid = arbitrate(claimed);
    for (int i = 0; i < N; i++) begin
      rise = EDGE && intr[i] && !m_prev[i];
      trig = (EDGE && le[i]) ? rise : intr[i];
      case (m_st[i])
        0: if (trig) m_st[i] = 1;
        1: if (claimed == i + 1) m_st[i] = 2;
        default: begin
          if (complete && int'(cid) == i + 1) begin
            m_st[i] = (m_defer[i] || (le[i] && rise)) ? 1 : 0;
            m_defer[i] = 0;
          end else if (le[i] && rise) begin
            m_defer[i] = 1;
          end
        end
      endcase
      m_prev[i] = intr[i];
    end
    m_id = nid;
  endtask

  task automatic tick();
    logic [N-1:0] exp_ip;
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < N; i++) exp_ip[i] = (m_st[i] == 1);
    check_eq("ip", ip, exp_ip);
    check_eq("irq_id", irq_id, m_id[3:0]);
    check_eq("irq", irq, m_id != 0);
    claim = 1'b0; complete = 1'b0; cid = '0;
  endtask

  task automatic set_prio(input int i, input int p);
    prio[i*W +: W] = p[W-1:0];
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; intr = '0; le = '0; ie = '1; prio = '0; thr = '0;
    claim = 1'b0; complete = 1'b0; cid = '0;
    tick();
    check_eq("reset_ip", ip, 0);
    check_eq("reset_irq", irq, 0);
    rst = 1'b0;

    // single source
    set_prio(2, 5); intr[2] = 1'b1;
    tick(); check_eq("s_ip_lat1", ip[2], 1); check_eq("s_irq_lat1", irq, 0);
    tick(); check_eq("s_id", irq_id, 3); check_eq("s_irq", irq, 1);
    claim = 1'b1; tick();
    check_eq("s_claim_ip", ip[2], 0); check_eq("s_claim_id", irq_id, 0);
    complete = 1'b1; cid = 4'd3; tick(); check_eq("s_cmp_ip", ip[2], 0);
    tick(); check_eq("s_repend", ip[2], 1);
    tick(); check_eq("s_repend_id", irq_id, 3);
    intr = '0; prio = '0; do_reset();

    // arbitration
    set_prio(1, 3); set_prio(4, 3); set_prio(6, 7);
    intr = 8'b0101_0010; tick(); intr = '0; tick();
    check_eq("a_id7", irq_id, 7);
    claim = 1'b1; tick(); check_eq("a_tie", irq_id, 2);
    thr = 3'd3; tick(); check_eq("a_thr", irq_id, 0);
    thr = 3'd0; tick(); check_eq("a_thr_back", irq_id, 2);
    do_reset();

    // masking
    ie[6] = 1'b0; intr = 8'b0100_0010; tick(); intr = '0; tick();
    check_eq("m_ie_id", irq_id, 2); check_eq("m_ie_ip", ip[6], 1);
    ie[6] = 1'b1; set_prio(6, 0); tick(); tick();
    check_eq("m_p0_id", irq_id, 2); check_eq("m_p0_ip", ip[6], 1);

    // illegal handshakes
    thr = 3'd7; tick(); check_eq("i_id0", irq_id, 0);
    claim = 1'b1; tick(); check_eq("i_claim0", ip, 8'b0100_0010);
    complete = 1'b1; cid = 4'd0; tick();
    complete = 1'b1; cid = 4'd2; tick();
    complete = 1'b1; cid = 4'd9; tick(); check_eq("i_cmp", ip, 8'b0100_0010);
    thr = 3'd0; prio = '0; do_reset();

`ifdef INTR_CTRL_EDGE_EN
    le[0] = 1'b1; set_prio(0, 5);
    intr[0] = 1'b1; tick(); intr[0] = 1'b0; tick();
    check_eq("e_id", irq_id, 1);
    claim = 1'b1; tick(); check_eq("e_claim", ip[0], 0);
    intr[0] = 1'b1; tick(); intr[0] = 1'b0; tick();
    complete = 1'b1; cid = 4'd1; tick(); check_eq("e_defer", ip[0], 1);
    le = '0; prio = '0; do_reset();
`endif

    // reset mid-operation with pending and in-service sources
    set_prio(3, 4); set_prio(5, 6); intr = 8'b0010_1000; tick(); tick();
    claim = 1'b1; tick();
    rst = 1'b1; tick();
    check_eq("r_ip", ip, 0); check_eq("r_irq", irq, 0); check_eq("r_id", irq_id, 0);
    rst = 1'b0; tick(); check_eq("r_repend", ip, 8'b0010_1000);
    intr = '0; do_reset();

    // random
    for (int k = 0; k < 3000; k++) begin
      intr = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 15) == 0) prio = (N*W)'($urandom);
      if ($urandom_range(0, 15) == 0) ie = N'($urandom | $urandom);
      if ($urandom_range(0, 31) == 0) thr = W'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) le = EDGE ? N'($urandom) : '0;
      claim = ($urandom_range(0, 2) == 0);
      complete = ($urandom_range(0, 1) == 0);
      cid = 4'($urandom_range(0, 10));
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/intr_ctrl_target.md
# intr_ctrl_target

- Receiving end of the peripheral interrupt lines: takes the level-triggered `intr_o` wires from `NumSrc` peripherals.
- Latches each line into a pending bit through a per-source gateway.
- Arbitrates by priority against a threshold and presents one target interrupt with a source ID.
- A claim/complete handshake blocks each source while software services it. Sits between peripheral interrupt outputs and a CPU's external-interrupt input.

## Interface
- `NumSrc`, 8: number of interrupt sources (1..63).
- `PrioW`, 3: priority width; priority 0 = never interrupts.
- `IdW`, `$clog2(NumSrc+1)`: ID width; ID 0 = none, source i has ID i+1. Derived, not overridden.
- `clk_i` input 1: clock.
- `rst_i` input 1: reset, synchronous, active-high.
- `intr_i` input NumSrc: peripheral interrupt lines.
- `le_i` input NumSrc: per-source 1 = edge-triggered, 0 = level. Used only with `INTR_CTRL_EDGE_EN`.
- `ie_i` input NumSrc: per-source enable.
- `prio_i` input NumSrc*PrioW: packed priorities; source i at `[i*PrioW +: PrioW]`.
- `threshold_i` input PrioW: only priority > threshold interrupts.
- `claim_i` input 1: single-cycle claim strobe; claims the current `irq_id_o`.
- `complete_i` input 1: single-cycle completion strobe.
- `complete_id_i` input IdW: ID being completed.
- `ip_o` output NumSrc: pending bits. Reset 0.
- `irq_o` output 1: target interrupt, registered. Reset 0.
- `irq_id_o` output IdW: winning ID, registered. Reset 0.

## Operation
- Each source has a gateway FSM with states IDLE, PENDING and INSVC. Reset state is IDLE.
  - IDLE → PENDING when the trigger is seen: level source with `intr_i[i]`=1, or edge source with a rising edge.
  - PENDING → INSVC on `claim_i` with `irq_id_o` = i+1.
  - INSVC → IDLE on `complete_i` with `complete_id_i` = i+1.
- `ip_o[i]` = (state == PENDING).
- `ie_i` does not gate pending; it gates arbitration only.
- Level sources:
  - A line still high after completion re-pends on the following edge.
  - A line dropping while PENDING keeps the source PENDING, since the pending bit is latched.
- Eligibility: PENDING & `ie_i[i]` & prio > `threshold_i` & prio != 0.
- Winner: highest priority; on a tie, the lowest index wins.
- `irq_id_o` = winner ID, or 0 if no source is eligible. `irq_o` = (`irq_id_o` != 0).
- Claim rules:
  - `claim_i` with `irq_id_o`=0 is ignored.
  - On the claim edge, the arbiter next-state masks the claimed source, so `irq_id_o` never presents a stale claimed ID.
- Completion rules:
  - `complete_i` naming ID 0, an out-of-range ID, or a source not in INSVC is ignored, with no state change.
- Simultaneous claim and complete on different IDs: both take effect in the same cycle.
  - The same ID cannot be both claimed and completed in one cycle, because PENDING and INSVC are exclusive.
- Changes to `ie_i`, `prio_i` or `threshold_i` re-arbitrate and are visible on `irq_id_o` one edge later.
- Reset mid-operation: all gateways go to IDLE and all outputs go to 0 at the next edge. Any in-service claim is dropped.

## Timing
- Trigger sampled at edge E0: `ip_o` = 1 after E0; `irq_o` and `irq_id_o` updated after E1, a 2-cycle latency.
- Claim at edge E: `ip_o[i]` = 0 and `irq_id_o` = next winner, both after E.
- Complete at edge E: state IDLE after E. A still-high level source shows `ip_o` after E+1 and `irq_o` after E+2.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `INTR_CTRL_EDGE_EN` defined:
  - `le_i` is honoured; the gateway holds a rising-edge detector (`intr_i` delayed flop, reset 0).
  - An edge arriving while PENDING is absorbed.
  - An edge arriving while INSVC sets a deferred bit. On complete, a set deferred bit sends the gateway INSVC → PENDING directly, and the deferred bit clears.
- Undefined:
  - `le_i` is ignored (all sources level).
  - No edge or deferred flops.
  - The port remains in the interface.

## Structure
- Shared package `intr_ctrl_pkg`:
  - gateway state enum (`GwIdle`, `GwPending`, `GwInsvc`);
  - `id_width(num_src)` function;
  - the `IdNone = 0` constant.
- One sub-module, `intr_ctrl_gateway`: single-source FSM plus edge/deferred logic, instantiated NumSrc times via generate.
- The arbiter is a priority/index reduction in the top.

## Test plan
- Single source: `intr_i[2]`=1 with prio 5, threshold 0, enabled → `ip_o[2]` after 1 cycle; `irq_id_o`=3 and `irq_o`=1 after 2 cycles. Claim → `ip_o[2]`=0 and `irq_id_o`=0 the next cycle. Complete ID 3 with line still high → re-pends.
- Arbitration: sources 1 and 4 at prio 3 and source 6 at prio 7 → ID 7. Claim → ID 2 (tie between sources 1 and 4 goes to the lower index). Threshold 3 → ID 0.
- Masking: `ie_i[6]`=0 or prio 0 → source 6 stays PENDING in `ip_o` but never wins.
- Illegal handshakes: claim when ID=0, complete ID 0, complete a PENDING source, complete ID 9 with NumSrc=8 → no state change.
- Edge mode (macro on): `le_i[0]`=1; pulse → PENDING. Claim, then a second pulse while INSVC, then complete → PENDING again immediately.
- Reset: assert `rst_i` with sources in PENDING and INSVC → `ip_o`=0, `irq_o`=0, `irq_id_o`=0 after one edge. Level sources re-pend after reset is released.
